uart16550_stream_ctrl: RTL and testbench

// - Wishbone master sitting directly upstream of iob_uart16550: replaces the bench/CPU register sequencing.
// - After reset, programs the divisor latch, LCR and FCR itself.
// - Then moves bytes from a valid/ready TX stream into THR and bytes from RBR out onto a valid/ready RX stream, polling LSR.

---
 rtl/uart16550_stream_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart16550_stream_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart16550_stream_ctrl.sv
// Wishbone master for iob_uart16550: programs divisor/LCR/FCR after reset, then
// polls LSR to move bytes between valid/ready streams and the THR/RBR registers.
module uart16550_stream_ctrl #(
    parameter logic [15:0] DIVISOR       = 16'd2,
    parameter logic [7:0]  LCR_VAL       = 8'h03,
    parameter logic [7:0]  FCR_VAL       = 8'h07,
    parameter int          TX_FIFO_DEPTH = 16,
    parameter int          POLL_GAP      = 4
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic        init_done_o,
    output logic        rx_err_o
);

    localparam logic [3:0] I_LCRD = 4'd0;
    localparam logic [3:0] I_DLL  = 4'd1;
    localparam logic [3:0] I_DLM  = 4'd2;
    localparam logic [3:0] I_LCR  = 4'd3;
    localparam logic [3:0] I_FCR  = 4'd4;
    localparam logic [3:0] GAP    = 4'd5;
    localparam logic [3:0] POLL   = 4'd6;
    localparam logic [3:0] RX_RD  = 4'd7;
    localparam logic [3:0] TX_LD  = 4'd8;
    localparam logic [3:0] TX_WR  = 4'd9;

    localparam logic [4:0]  CREDIT_INIT = 5'(TX_FIFO_DEPTH);
    localparam logic [15:0] GAP_LAST    = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
    // A zero gap skips the GAP state entirely so the next poll launches one edge sooner.
    localparam logic [3:0]  IDLE_NEXT   = (POLL_GAP > 0) ? GAP : POLL;

    logic [3:0]  r_state;
    logic        r_cyc;
    logic [4:0]  r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [7:0]  r_m_tdata;
    logic        r_m_tvalid;
    logic [7:0]  r_tx_byte;
    logic [4:0]  r_credit;
    logic [15:0] r_gap_cnt;
    logic        r_init_done;
    logic        r_rx_err;

    logic        w_bus_state;
    logic [4:0]  w_req_adr;
    logic [7:0]  w_req_byte;
    logic        w_req_we;
    logic [7:0]  w_rd_byte;
    logic        w_ack;
    logic        w_take;

    assign w_ack  = r_cyc & wb_ack_i;
    assign w_take = (r_state == TX_LD) && s_tvalid && (r_credit != 5'd0);

    assign s_tready    = w_take;
    assign m_tdata     = r_m_tdata;
    assign m_tvalid    = r_m_tvalid;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_we_o     = r_we;
    assign wb_stb_o    = r_cyc;
    assign wb_cyc_o    = r_cyc;
    assign wb_sel_o    = r_sel;
    assign init_done_o = r_init_done;
    assign rx_err_o    = r_rx_err;

    // Per-state bus request: register address, write byte and direction.
    always_comb begin
        w_bus_state = 1'b1;
        w_req_adr   = 5'd0;
        w_req_byte  = 8'h00;
        w_req_we    = 1'b1;
        case (r_state)
            I_LCRD: begin
                w_req_adr  = 5'd3;
                w_req_byte = LCR_VAL | 8'h80;
            end
            I_DLL: begin
                w_req_adr  = 5'd0;
                w_req_byte = DIVISOR[7:0];
            end
            I_DLM: begin
                w_req_adr  = 5'd1;
                w_req_byte = DIVISOR[15:8];
            end
            I_LCR: begin
                w_req_adr  = 5'd3;
                w_req_byte = LCR_VAL;
            end
            I_FCR: begin
                w_req_adr  = 5'd2;
                w_req_byte = FCR_VAL;
            end
            POLL: begin
                w_req_adr = 5'd5;
                w_req_we  = 1'b0;
            end
            RX_RD: begin
                w_req_adr = 5'd0;
                w_req_we  = 1'b0;
            end
            TX_WR: begin
                w_req_adr  = 5'd0;
                w_req_byte = r_tx_byte;
            end
            default: begin
                w_bus_state = 1'b0;
            end
        endcase
    end

    // Read-data lane selected by the latched address.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_adr[1:0])
            2'd0:    w_rd_byte = wb_dat_i[7:0];
            2'd1:    w_rd_byte = wb_dat_i[15:8];
            2'd2:    w_rd_byte = wb_dat_i[23:16];
            2'd3:    w_rd_byte = wb_dat_i[31:24];
            default: w_rd_byte = 8'h00;
        endcase
    end

    // Sequencer: bus cycle launch/completion, init order, polling and stream moves.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_state     <= I_LCRD;
            r_cyc       <= 1'b0;
            r_adr       <= 5'd0;
            r_dat       <= 32'd0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_m_tdata   <= 8'd0;
            r_m_tvalid  <= 1'b0;
            r_tx_byte   <= 8'd0;
            r_credit    <= 5'd0;
            r_gap_cnt   <= 16'd0;
            r_init_done <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_rx_err <= 1'b0;
            if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            // Launching only while cyc is low guarantees an idle cycle after every ack.
            if (w_bus_state && !r_cyc) begin
                r_cyc <= 1'b1;
                r_adr <= w_req_adr;
                r_dat <= {24'd0, w_req_byte} << {w_req_adr[1:0], 3'b000};
                r_we  <= w_req_we;
                r_sel <= 4'b0001 << w_req_adr[1:0];
            end else if (w_bus_state && w_ack) begin
                r_cyc <= 1'b0;
                case (r_state)
                    I_LCRD: r_state <= I_DLL;
                    I_DLL:  r_state <= I_DLM;
                    I_DLM:  r_state <= I_LCR;
                    I_LCR:  r_state <= I_FCR;
                    I_FCR: begin
                        r_init_done <= 1'b1;
                        r_state     <= IDLE_NEXT;
                    end
                    POLL: begin
                        r_rx_err <= |w_rd_byte[4:1];
                        // A waiting RX byte wins over TX so the receive FIFO cannot overrun.
                        if (w_rd_byte[0] && !r_m_tvalid) begin
                            r_state <= RX_RD;
                        end else if (w_rd_byte[5] && s_tvalid) begin
                            r_credit <= CREDIT_INIT;
                            r_state  <= TX_LD;
                        end else begin
                            r_state <= IDLE_NEXT;
                        end
                    end
                    RX_RD: begin
                        r_m_tdata  <= w_rd_byte;
                        r_m_tvalid <= 1'b1;
                        r_state    <= IDLE_NEXT;
                    end
                    TX_WR:   r_state <= TX_LD;
                    default: r_state <= IDLE_NEXT;
                endcase
            end else if (r_state == GAP) begin
                if (r_gap_cnt == GAP_LAST) begin
                    r_gap_cnt <= 16'd0;
                    r_state   <= POLL;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                end
            end else if (r_state == TX_LD) begin
                if (w_take) begin
                    r_tx_byte <= s_tdata;
                    r_credit  <= r_credit - 5'd1;
                    r_state   <= TX_WR;
                end else begin
                    r_state <= IDLE_NEXT;
                end
            end else if (r_state > TX_WR) begin
                r_state <= I_LCRD;
            end else begin
                r_state <= r_state;
            end
        end
    end

endmodule

// File: tb/tb_uart16550_stream_ctrl.sv
// Randomized bench for uart16550_stream_ctrl: a behavioural UART register model answers
// the Wishbone bus while byte queues predict THR writes and RX stream output.
module tb_uart16550_stream_ctrl;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic       we;
        logic [4:0] adr;
        logic [3:0] sel;
        logic [31:0] dat;
    } txn_t;

    localparam int K_LSR = 1;
    localparam int K_RBR = 2;
    localparam int K_THR = 3;
    localparam int K_OTH = 4;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        init_done_o;
    logic        rx_err_o;

    uart16550_stream_ctrl #(
        .DIVISOR(16'd2), .LCR_VAL(8'h1B), .FCR_VAL(8'h07),
        .TX_FIFO_DEPTH(DEPTH), .POLL_GAP(4)
    ) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
        .init_done_o(init_done_o), .rx_err_o(rx_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] tx_src[$];
    logic [7:0] tx_ref[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] exp_rx[$];
    txn_t       log_q[$];

    logic thre_always = 1'b0, thre_once = 1'b0, thre_rand = 1'b0;
    logic err_once = 1'b0, err_rand = 1'b0;
    logic hold_thr = 1'b0, cons_hold = 1'b0;
    int   thr_writes = 0, rbr_reads = 0, acc_cnt = 0, err_hi = 0, wsince = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 400 && !init_done_o; i++) @(negedge clk);
        chk("init_timeout", init_done_o, 1'b1);
    endtask

    task automatic check_init_log();
        txn_t exp_init[5];
        exp_init[0] = {1'b1, 5'd3, 4'b1000, 32'h9B00_0000};
        exp_init[1] = {1'b1, 5'd0, 4'b0001, 32'h0000_0002};
        exp_init[2] = {1'b1, 5'd1, 4'b0010, 32'h0000_0000};
        exp_init[3] = {1'b1, 5'd3, 4'b1000, 32'h1B00_0000};
        exp_init[4] = {1'b1, 5'd2, 4'b0100, 32'h0007_0000};
        for (int i = 0; i < 5; i++) begin
            if (log_q.size() > i) chk($sformatf("init%0d", i), log_q[i], exp_init[i]);
            else chk($sformatf("init%0d_missing", i), 1'b0, 1'b1);
        end
    endtask

    // Wishbone slave: behavioural UART registers, random ack latency, protocol checks.
    initial begin
        txn_t cur, first;
        logic started = 1'b0;
        logic err_pend = 1'b0;
        int   lat = 0, pred = 0, kind;
        logic [7:0] lsr, b;
        logic th;
        logic [31:0] r32;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wb_rst_i) begin
                wb_ack_i = 1'b0; started = 1'b0; pred = 0; err_pend = 1'b0; wsince = 0;
            end else if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                wb_dat_i = 32'h0;
                chk("no_b2b", {wb_cyc_o, wb_stb_o}, 2'b00);
                chk("rx_err", rx_err_o, err_pend);
                err_pend = 1'b0;
            end else if (wb_cyc_o && wb_stb_o) begin
                cur = {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};
                if (!wb_we_o && wb_adr_o == 5'd5) kind = K_LSR;
                else if (!wb_we_o && wb_adr_o == 5'd0) kind = K_RBR;
                else if (wb_we_o && wb_adr_o == 5'd0 && init_done_o) kind = K_THR;
                else kind = K_OTH;
                if (!started) begin
                    started = 1'b1; first = cur; lat = $urandom_range(0, 2);
                end
                if (lat > 0) begin
                    lat--;
                end else if (!(hold_thr && kind == K_THR)) begin
                    chk("stable", cur, first);
                    chk("sel", wb_sel_o, 4'b0001 << wb_adr_o[1:0]);
                    started = 1'b0;
                    log_q.push_back(cur);
                    if (pred != 0) chk("order", kind, pred);
                    pred = 0;
                    r32 = $urandom;
                    if (kind == K_LSR) begin
                        lsr = 8'h00;
                        lsr[0] = (rx_fifo.size() > 0);
                        th = thre_always || thre_once || (thre_rand && $urandom_range(0, 1) == 1);
                        thre_once = 1'b0;
                        lsr[5] = th;
                        lsr[6] = th;
                        if (err_once) lsr[4:1] = 4'b0001;
                        else if (err_rand && $urandom_range(0, 7) == 0) lsr[4:1] = 4'($urandom_range(1, 15));
                        err_once = 1'b0;
                        err_pend = |lsr[4:1];
                        if (th) wsince = 0;
                        if (lsr[0] && !m_tvalid) pred = K_RBR;
                        else if (th && s_tvalid) pred = K_THR;
                        else pred = K_LSR;
                        wb_dat_i = {r32[31:16], lsr, r32[7:0]};
                    end else if (kind == K_RBR) begin
                        chk("rbr_slot_free", m_tvalid, 1'b0);
                        b = (rx_fifo.size() > 0) ? rx_fifo.pop_front() : 8'h00;
                        wb_dat_i = {r32[31:8], b};
                        rbr_reads++;
                        pred = K_LSR;
                    end else if (kind == K_THR) begin
                        thr_writes++;
                        wsince++;
                        chk("burst_limit", wsince <= DEPTH, 1'b1);
                        chk("thr_lane", wb_dat_o[31:8], 24'h0);
                        if (tx_ref.size() == 0) chk("thr_extra", 1'b1, 1'b0);
                        else chk("thr_data", wb_dat_o[7:0], tx_ref.pop_front());
                    end
                    wb_ack_i = 1'b1;
                end
            end
        end
    end

    // TX stream source: presents queued bytes, never withdraws valid before acceptance.
    initial begin
        logic acc;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            acc = s_tvalid && s_tready;
            if (acc) begin
                acc_cnt++;
                chk("acc_after_init", init_done_o, 1'b1);
            end
            @(posedge clk);
            #1;
            if (acc) s_tvalid = 1'b0;
            if (!s_tvalid && tx_src.size() > 0) begin
                s_tdata  = tx_src.pop_front();
                s_tvalid = 1'b1;
            end
        end
    end

    // RX stream sink: random ready, checks order and hold stability.
    initial begin
        logic held = 1'b0;
        logic [7:0] held_data = 8'h00;
        m_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_err_o) err_hi++;
            m_tready = cons_hold ? 1'b0 : 1'($urandom_range(0, 1));
            if (m_tvalid && !wb_rst_i) begin
                if (held) chk("m_hold", m_tdata, held_data);
                if (m_tready) begin
                    held = 1'b0;
                    if (exp_rx.size() == 0) chk("m_extra", 1'b1, 1'b0);
                    else chk("m_data", m_tdata, exp_rx.pop_front());
                end else begin
                    held = 1'b1;
                    held_data = m_tdata;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic found;
        int n;
        wb_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("rst_bus", {wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o}, 42'h0);
        chk("rst_stream", {s_tready, m_tvalid, m_tdata}, 10'h0);
        chk("rst_flags", {init_done_o, rx_err_o}, 2'b00);
        log_q.delete();
        wb_rst_i = 1'b0;
        wait_init();
        check_init_log();

        // TX burst: 20 queued bytes, 16 per THRE observation
        cyc(5);
        acc_cnt = 0; thr_writes = 0;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            tx_src.push_back(b);
            tx_ref.push_back(b);
        end
        cyc(50);
        chk("no_thre_no_tx", acc_cnt, 0);
        thre_once = 1'b1;
        cyc(400);
        chk("burst16_writes", thr_writes, 16);
        chk("burst16_accepts", acc_cnt, 16);
        thre_once = 1'b1;
        cyc(200);
        chk("burst20_writes", thr_writes, 20);
        chk("tx_ref_empty", tx_ref.size(), 0);

        // RX backpressure: second byte waits for the slot
        cons_hold = 1'b1;
        rbr_reads = 0;
        rx_fifo.push_back(8'hA5); exp_rx.push_back(8'hA5);
        b = 8'($urandom);
        rx_fifo.push_back(b); exp_rx.push_back(b);
        cyc(100);
        chk("hold_rbr_reads", rbr_reads, 1);
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data", m_tdata, 8'hA5);
        cons_hold = 1'b0;
        cyc(100);
        chk("release_rbr_reads", rbr_reads, 2);
        chk("release_rx_empty", exp_rx.size(), 0);

        // LSR 0x63 with both directions pending: error pulse and RX first
        tx_src.push_back(8'h3C); tx_ref.push_back(8'h3C);
        cyc(5);
        err_hi = 0; thr_writes = 0; rbr_reads = 0;
        rx_fifo.push_back(8'h5A); exp_rx.push_back(8'h5A);
        err_once = 1'b1; thre_once = 1'b1;
        cyc(80);
        chk("err_pulse_cycles", err_hi, 1);
        chk("err_rbr", rbr_reads, 1);
        thre_once = 1'b1;
        cyc(80);
        chk("err_thr", thr_writes, 1);
        chk("err_rx_empty", exp_rx.size(), 0);

        // Randomized traffic
        thre_rand = 1'b1; err_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom); tx_src.push_back(b); tx_ref.push_back(b);
            end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom); rx_fifo.push_back(b); exp_rx.push_back(b);
            end
            cyc($urandom_range(20, 60));
        end
        thre_rand = 1'b0; err_rand = 1'b0; thre_always = 1'b1;
        for (int i = 0; i < 5000 && (tx_ref.size() > 0 || exp_rx.size() > 0); i++) cyc(1);
        chk("drain_tx", tx_ref.size(), 0);
        chk("drain_rx", exp_rx.size(), 0);
        thre_always = 1'b0;

        // Reset while a THR write is waiting for ack
        cyc(10);
        hold_thr = 1'b1;
        tx_src.push_back(8'hE7); tx_ref.push_back(8'hE7);
        cyc(3);
        thre_once = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_we_o && wb_adr_o == 5'd0) found = 1'b1;
        end
        chk("thr_pending_seen", found, 1'b1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("midrst_done", init_done_o, 1'b0);
        tx_ref.delete();
        hold_thr = 1'b0;
        thre_once = 1'b0;
        log_q.delete();
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        wait_init();
        check_init_log();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
